// File: rtl/dma_sequencer.sv
// dma_sequencer: arbitrates queue instructions and cache requests onto the single dma_uart port.
// Optional busy watchdog is compiled in when DMA_SEQ_TIMEOUT_EN is defined.
module dma_sequencer #(
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned DAT_W       = 18,
    parameter int unsigned INSTR_W     = 22,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               q_empty,
    output logic               q_re,
    input  logic [INSTR_W-1:0] q_instr,
    input  logic               cache_req,
    input  logic               cache_wr,
    input  logic [ADDR_W-1:0]  cache_addr,
    input  logic [DAT_W-1:0]   cache_wdat,
    output logic               cache_done,
    output logic [DAT_W-1:0]   cache_rdat,
    output logic [ADDR_W-1:0]  dma_addr,
    output logic [DAT_W-1:0]   dma_dat_w,
    output logic               dma_we,
    output logic               dma_re,
    input  logic [DAT_W-1:0]   dma_dat_r,
    input  logic               dma_busy,
    output logic               freeze,
    output logic               timeout_err
);
    localparam int unsigned VLD_BIT  = INSTR_W - 1;
    localparam int unsigned WR_BIT   = INSTR_W - 2;
    localparam int unsigned ADDR_LSB = INSTR_W - 2 - ADDR_W;

    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, ARM, WAIT} state_t;

    state_t           state, state_nx;
    logic             q_ready, c_ready;
    logic             pick_q, pick_c, fetch_ok, op_end, op_abort;
    logic             wd_expired;
    logic             op_wr, op_cache, rr_last_cache;
    logic [DAT_W-1:0] last_rd;
    logic             unused_instr;

    assign unused_instr = ^q_instr[ADDR_LSB-1:0];

    // The pop must land in the IDLE cycle so the word is on q_instr during FETCH.
    assign q_re = reset_n & pick_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        pick_q   = 1'b0;
        pick_c   = 1'b0;
        fetch_ok = 1'b0;
        op_end   = 1'b0;
        op_abort = 1'b0;
        q_ready  = !q_empty;
        // cache_req is still high during its own done pulse; do not regrant it
        c_ready  = cache_req && !cache_done;
        case (state)
            IDLE: begin
                if (!dma_busy) begin
                    if (q_ready && (!c_ready || rr_last_cache)) begin
                        pick_q   = 1'b1;
                        state_nx = FETCH;
                    end else if (c_ready) begin
                        pick_c   = 1'b1;
                        state_nx = ISSUE;
                    end
                end
            end
            FETCH: begin
                if (q_instr[VLD_BIT]) begin
                    fetch_ok = 1'b1;
                    state_nx = ISSUE;
                end else begin
                    state_nx = IDLE;
                end
            end
            ISSUE: state_nx = ARM;
            ARM:   state_nx = WAIT;
            WAIT: begin
                if (!dma_busy) begin
                    op_end   = 1'b1;
                    state_nx = IDLE;
                end else if (wd_expired) begin
                    op_abort = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operation datapath: address/data latched at grant and held until the op retires.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            freeze        <= 1'b0;
            dma_we        <= 1'b0;
            dma_re        <= 1'b0;
            cache_done    <= 1'b0;
            cache_rdat    <= '0;
            dma_addr      <= '0;
            dma_dat_w     <= '0;
            last_rd       <= '0;
            op_wr         <= 1'b0;
            op_cache      <= 1'b0;
            rr_last_cache <= 1'b1;
        end else begin
            freeze     <= (state_nx != IDLE);
            dma_we     <= 1'b0;
            dma_re     <= 1'b0;
            cache_done <= 1'b0;
            if (pick_q) rr_last_cache <= 1'b0;
            if (pick_c) begin
                rr_last_cache <= 1'b1;
                op_cache      <= 1'b1;
                op_wr         <= cache_wr;
                dma_addr      <= cache_addr;
                dma_dat_w     <= cache_wdat;
                dma_we        <= cache_wr;
                dma_re        <= !cache_wr;
            end
            if (fetch_ok) begin
                op_cache  <= 1'b0;
                op_wr     <= q_instr[WR_BIT];
                dma_addr  <= q_instr[ADDR_LSB +: ADDR_W];
                dma_dat_w <= last_rd;
                dma_we    <= q_instr[WR_BIT];
                dma_re    <= !q_instr[WR_BIT];
            end
            if (op_end) begin
                if (!op_wr) last_rd <= dma_dat_r;
                if (op_cache) begin
                    cache_done <= 1'b1;
                    if (!op_wr) cache_rdat <= dma_dat_r;
                end
            end
        end
    end

`ifdef DMA_SEQ_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_cnt;

    // Busy watchdog: cleared in ARM, counts WAIT cycles, error is sticky until reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == ARM)       wd_cnt <= '0;
            else if (state == WAIT) wd_cnt <= wd_cnt + WD_W'(1);
            if (op_abort) timeout_err <= 1'b1;
        end
    end

    assign wd_expired = (state == WAIT) && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
`else
    localparam int unsigned UNUSED_TIMEOUT = TIMEOUT_CYC;

    assign wd_expired  = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule
